rule_port_filter: RTL

- Parametrised successor to the fixed four-group rule port checker.
- Takes candidate rule IDs from the string matcher, each with the packet's L4 ports and protocol.
- Fetches the rule's port-group list from the external rule2pg table and evaluates NUM_PG groups in parallel against an internal, runtime-loadable port-group register file.
- Emits only port-qualified rules through a valid/ready FIFO with full backpressure, replacing the old fire-and-forget pipeline.

---
 rtl/rule_port_filter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/rule_port_filter.sv
// rule_port_filter: fetches a rule's port-group list, checks L4 ports
// against a loadable group file, queues qualified rules in a FWFT FIFO.
module rule_port_filter #(
  parameter int RULE_AWIDTH = 13,
  parameter int NUM_PG      = 4,
  parameter int PG_AWIDTH   = 5,
  parameter int RD_LAT      = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [RULE_AWIDTH-1:0]          in_rule,
  input  logic [15:0]                     in_src_port,
  input  logic [15:0]                     in_dst_port,
  input  logic                            in_tcp,
  output logic                            tbl_rd,
  output logic [RULE_AWIDTH-1:0]          tbl_addr,
  input  logic [NUM_PG*(PG_AWIDTH+1)-1:0] tbl_data,
  input  logic                            cfg_we,
  input  logic [PG_AWIDTH-1:0]            cfg_addr,
  input  logic [35:0]                     cfg_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [RULE_AWIDTH-1:0]          out_rule,
  output logic [31:0]                     match_cnt,
  output logic [31:0]                     nomatch_cnt
);

  localparam int FW  = PG_AWIDTH + 1;
  localparam int PGN = 1 << PG_AWIDTH;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  logic accept;

  logic [RD_LAT-1:0]      d_v;
  logic [RD_LAT-1:0]      d_tcp;
  logic [RULE_AWIDTH-1:0] d_rule [RD_LAT];
  logic [15:0]            d_src  [RD_LAT];
  logic [15:0]            d_dst  [RD_LAT];

  logic                        c_v;
  logic                        c_tcp;
  logic [RULE_AWIDTH-1:0]      c_rule;
  logic [15:0]                 c_src;
  logic [15:0]                 c_dst;
  logic [NUM_PG*FW-1:0]        c_pg;

  logic [35:0] pg_mem [PGN];

  logic [NUM_PG-1:0] slot_hit;
  logic              push;
  logic              reject;
  logic              pop;

  logic [RULE_AWIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic [CW-1:0]          fifo_cnt;

  logic [CW:0] inflight;
  logic [CW:0] used;

  function automatic logic entry_hit(
    input logic [35:0] e,
    input logic [15:0] s,
    input logic [15:0] d,
    input logic        tcp
  );
    logic pok;
    logic sin;
    logic din;
    logic pass;
    pok = (e[35:34] == 2'b00) |
          ((e[35:34] == 2'b01) & tcp) |
          ((e[35:34] == 2'b10) & ~tcp);
    sin = (s >= e[31:16]) && (s <= e[15:0]);
    din = (d >= e[31:16]) && (d <= e[15:0]);
    case (e[33:32])
      2'b00:   pass = din;
      2'b01:   pass = sin;
      2'b10:   pass = sin | din;
      default: pass = sin & din;
    endcase
    return pok & pass;
  endfunction

  assign accept   = in_valid & in_ready;
  assign tbl_rd   = accept & (in_rule != '0);
  assign tbl_addr = in_rule - RULE_AWIDTH'(1);

  // Valid bits of the table-latency delay line
  always_ff @(posedge clk) begin
    if (rst) begin
      d_v <= '0;
    end else begin
      d_v[0] <= tbl_rd;
      for (int i = 1; i < RD_LAT; i++)
        d_v[i] <= d_v[i-1];
    end
  end

  // Packet fields ride alongside the table read until tbl_data lands
  always_ff @(posedge clk) begin
    d_rule[0] <= in_rule;
    d_src[0]  <= in_src_port;
    d_dst[0]  <= in_dst_port;
    d_tcp[0]  <= in_tcp;
    for (int i = 1; i < RD_LAT; i++) begin
      d_rule[i] <= d_rule[i-1];
      d_src[i]  <= d_src[i-1];
      d_dst[i]  <= d_dst[i-1];
      d_tcp[i]  <= d_tcp[i-1];
    end
  end

  // Compare-stage valid
  always_ff @(posedge clk) begin
    if (rst)
      c_v <= 1'b0;
    else
      c_v <= d_v[RD_LAT-1];
  end

  // Compare-stage payload: aligned packet fields plus group list
  always_ff @(posedge clk) begin
    c_rule <= d_rule[RD_LAT-1];
    c_src  <= d_src[RD_LAT-1];
    c_dst  <= d_dst[RD_LAT-1];
    c_tcp  <= d_tcp[RD_LAT-1];
    c_pg   <= tbl_data;
  end

  // Group file; reset leaves every entry disabled (proto 11)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PGN; i++)
        pg_mem[i] <= {2'b11, 34'd0};
    end else if (cfg_we) begin
      pg_mem[cfg_addr] <= cfg_data;
    end
  end

  for (genvar k = 0; k < NUM_PG; k++) begin : g_slot
    logic [FW-1:0]        fld;
    logic [PG_AWIDTH-1:0] idx;
    assign fld = c_pg[k*FW +: FW];
    assign idx = fld[PG_AWIDTH-1:0] - PG_AWIDTH'(1);
    assign slot_hit[k] = (fld != '0) &
      entry_hit(pg_mem[idx], c_src, c_dst, c_tcp);
  end

  assign push   = c_v & (|slot_hit);
  assign reject = c_v & ~(|slot_hit);

  assign out_valid = ~rst & (fifo_cnt != '0);
  assign out_rule  = fifo_mem[rptr];
  assign pop       = out_valid & out_ready;

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (push & ~pop)
        fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop & ~push)
        fifo_cnt <= fifo_cnt - CW'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wptr] <= c_rule;
  end

  // Rules holding a credit but not yet resolved
  always_comb begin
    inflight = {{CW{1'b0}}, c_v};
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + {{CW{1'b0}}, d_v[i]};
  end

  assign used     = {1'b0, fifo_cnt} + inflight;
  assign in_ready = ~rst & (used < (CW+1)'(FIFO_DEPTH));

  // Saturating result counters
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt   <= '0;
      nomatch_cnt <= '0;
    end else begin
      if (push && (match_cnt != '1))
        match_cnt <= match_cnt + 32'd1;
      if (reject && (nomatch_cnt != '1))
        nomatch_cnt <= nomatch_cnt + 32'd1;
    end
  end

endmodule
